// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int MAX_WIDTH = 64;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fulladd.sv
// One-bit full adder, reused every cycle by the serial adder controller.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: streams operands LSB-first through one full adder over
// WIDTH cycles and presents the parallel sum with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// ADD   | one operand bit per cycle through u_fa
// DONE  | result valid, done pulse; always returns to IDLE
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_co;
    logic             r_busy;
    logic             r_done;
    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_last;

    fulladd u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = ADD;
            ADD:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_co     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ADD);
            r_done  <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= ci;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_carry  <= w_fa_co;
                    r_sum_sr <= {w_fa_s, r_sum_sr[WIDTH-1:1]};
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    // Result registers only move on the final bit so sum/co
                    // keep the previous answer for the whole operation.
                    if (w_last) begin
                        r_sum <= {w_fa_s, r_sum_sr[WIDTH-1:1]};
                        r_co  <= w_fa_co;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 2, 8 and 16.
module tb_serial_add_ctrl;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        st  [3];
    logic [15:0] av  [3];
    logic [15:0] bv  [3];
    logic        civ [3];
    bit          b2b    = 1'b0;
    bit          chk_en = 1'b0;
    int          cyc    = 0;
    int          total  = 0;
    int          bad    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int W = (g == 0) ? 2 : ((g == 1) ? 8 : 16);
        logic [W-1:0] w_sum;
        logic         w_co;
        logic         w_busy;
        logic         w_done;
        logic         m_live    = 1'b0;
        int           m_k       = 0;
        logic [W:0]   m_res     = '0;
        int           n_done    = 0;
        int           last_done = -1;

        serial_add_ctrl #(.WIDTH(W)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .start   (st[g]),
            .a       (av[g][W-1:0]),
            .b       (bv[g][W-1:0]),
            .ci      (civ[g]),
            .busy    (w_busy),
            .done    (w_done),
            .sum     (w_sum),
            .co      (w_co)
        );

        // Timeline model: m_k counts edges since the accepting edge.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                m_live <= 1'b0;
                m_k    <= 0;
            end else if (m_live) begin
                if (m_k == W) m_live <= 1'b0;
                else          m_k    <= m_k + 1;
            end else if (st[g]) begin
                m_live <= 1'b1;
                m_k    <= 0;
                m_res  <= {1'b0, av[g][W-1:0]} + {1'b0, bv[g][W-1:0]} + {{W{1'b0}}, civ[g]};
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("busy_w%0d", W), w_busy, (m_live && m_k < W));
                check($sformatf("done_w%0d", W), w_done, (m_live && m_k == W));
                if (m_live && m_k == W)
                    check($sformatf("result_w%0d", W), {w_co, w_sum}, m_res);
                if (!reset_n) begin
                    check($sformatf("rst_sum_w%0d", W), w_sum, 0);
                    check($sformatf("rst_co_w%0d", W), w_co, 0);
                end
                if (w_done) n_done <= n_done + 1;
                if (!b2b) begin
                    last_done <= -1;
                end else if (w_done) begin
                    if (last_done >= 0)
                        check($sformatf("spacing_w%0d", W), cyc - last_done, W + 2);
                    last_done <= cyc;
                end
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_op, input logic tci,
                          input logic [7:0] es, input logic eco, input string nm);
        int c0;
        int dcyc  = -1;
        int nbusy = 0;
        @(posedge clk); #2;
        av[1] = {8'h00, ta}; bv[1] = {8'h00, tb_op}; civ[1] = tci; st[1] = 1'b1;
        @(posedge clk); #2;
        st[1] = 1'b0; av[1] = 16'hFFFF; bv[1] = 16'hFFFF; civ[1] = 1'b1;
        c0 = cyc;
        for (int n = 0; n < 40 && dcyc < 0; n++) begin
            @(negedge clk);
            if (g_inst[1].w_busy) nbusy++;
            if (g_inst[1].w_done) begin
                dcyc = cyc;
                check({nm, "_sum"}, g_inst[1].w_sum, es);
                check({nm, "_co"}, g_inst[1].w_co, eco);
            end
        end
        check({nm, "_done_seen"}, (dcyc >= 0), 1);
        check({nm, "_latency"}, dcyc - c0, 8);
        check({nm, "_busy_cycles"}, nbusy, 8);
        @(posedge clk); #2;
    endtask

    task automatic stream(input int g, input int w);
        @(posedge clk); #2;
        st[g] = 1'b1;
        repeat (200 * (w + 2)) begin
            av[g]  = 16'($urandom);
            bv[g]  = 16'($urandom);
            civ[g] = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
        end
        st[g] = 1'b0;
        repeat (w + 4) @(posedge clk);
    endtask

    initial begin
        int nd;
        int dc [2];
        logic [8:0] ds [2];
        int nd0;
        int snap [3];

        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; av[k] = '0; bv[k] = '0; civ[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", g_inst[1].w_busy, 0);
        check("reset_done", g_inst[1].w_done, 0);
        check("reset_sum", g_inst[1].w_sum, 0);
        check("reset_co", g_inst[1].w_co, 0);

        run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry1");
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "carry2");

        // Start held through busy and done: only the IDLE sample counts.
        @(posedge clk); #2;
        av[1] = 16'h0012; bv[1] = 16'h0034; civ[1] = 1'b0; st[1] = 1'b1;
        @(posedge clk); #2;
        av[1] = 16'h00AA; bv[1] = 16'h00AA;
        nd = 0;
        for (int n = 0; n < 60 && nd < 2; n++) begin
            @(negedge clk);
            if (g_inst[1].w_done) begin
                dc[nd] = cyc;
                ds[nd] = {g_inst[1].w_co, g_inst[1].w_sum};
                nd++;
            end
        end
        st[1] = 1'b0;
        check("held_done_count", nd, 2);
        check("held_first", ds[0], 9'h046);
        check("held_second", ds[1], 9'h154);
        check("held_spacing", dc[1] - dc[0], 10);
        @(posedge clk); #2;

        // Asynchronous abort mid-operation.
        @(posedge clk); #2;
        av[1] = 16'h000F; bv[1] = 16'h000F; civ[1] = 1'b0; st[1] = 1'b1;
        @(posedge clk); #2;
        st[1] = 1'b0;
        repeat (3) @(posedge clk);
        #4 reset_n = 1'b0;
        #2;
        check("abort_busy", g_inst[1].w_busy, 0);
        check("abort_done", g_inst[1].w_done, 0);
        check("abort_sum", g_inst[1].w_sum, 0);
        check("abort_co", g_inst[1].w_co, 0);
        nd0 = g_inst[1].n_done;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (14) @(negedge clk);
        check("abort_no_done", g_inst[1].n_done, nd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_reset");

        snap[0] = g_inst[0].n_done;
        snap[1] = g_inst[1].n_done;
        snap[2] = g_inst[2].n_done;
        b2b = 1'b1;
        fork
            stream(0, 2);
            stream(1, 8);
            stream(2, 16);
        join
        @(negedge clk);
        b2b = 1'b0;
        check("b2b_count_w2", g_inst[0].n_done - snap[0], 200);
        check("b2b_count_w8", g_inst[1].n_done - snap[1], 200);
        check("b2b_count_w16", g_inst[2].n_done - snap[2], 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
